// File: rtl/lpc_frame_loader.sv
// rtl/lpc_frame_loader.sv - LPC frame shadow loader with per-boundary swap and underrun detection
module lpc_frame_loader #(
   parameter int NCOEF = 11,
   parameter int DW    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [DW-1:0]        in_data,
   output logic                 in_ready,
   input  logic [DW-1:0]        lpcrate,
   input  logic                 sample_tick,
   output logic                 start,
   output logic                 stop,
   output logic                 voiced,
   output logic [DW-1:0]        pulserate,
   output logic signed [DW-1:0] A0,
   output logic signed [DW-1:0] A1,
   output logic signed [DW-1:0] A2,
   output logic signed [DW-1:0] A3,
   output logic signed [DW-1:0] A4,
   output logic signed [DW-1:0] A5,
   output logic signed [DW-1:0] A6,
   output logic signed [DW-1:0] A7,
   output logic signed [DW-1:0] A8,
   output logic signed [DW-1:0] A9,
   output logic signed [DW-1:0] A10,
   output logic                 underrun,
   output logic [DW-1:0]        frame_count
);

   localparam int NWORDS = NCOEF + 2;
   localparam int IW     = $clog2(NWORDS);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t          r_state, w_state_nxt;
   logic [IW-1:0]   r_wr_idx;
   logic            r_sh_full;
   logic            r_sh_voiced;
   logic [DW-1:0]   r_sh_pulserate;
   logic [DW-1:0]   r_sh_a [NCOEF];
   logic            r_act_voiced;
   logic [DW-1:0]   r_act_pulserate;
   logic [DW-1:0]   r_act_a [NCOEF];
   logic [DW-1:0]   r_count;
   logic [DW-1:0]   r_frame_count;
   logic            r_start, r_stop, r_underrun;

   logic            w_accept;
   logic            w_last_word;
   logic [DW-1:0]   w_rate_m1;
   logic            w_boundary;
   logic            w_swap, w_start, w_stop, w_cnt_clr, w_cnt_inc;

   assign w_accept    = in_valid && !r_sh_full;
   assign w_last_word = (r_wr_idx == IW'(NWORDS - 1));
   // lpcrate of 0 behaves as 1; >= lets a shrunk rate force the next tick to a boundary
   assign w_rate_m1   = (lpcrate == '0) ? '0 : lpcrate - DW'(1);
   assign w_boundary  = (r_count >= w_rate_m1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_swap      = 1'b0;
      w_start     = 1'b0;
      w_stop      = 1'b0;
      w_cnt_clr   = 1'b0;
      w_cnt_inc   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_sh_full) begin
               w_swap      = 1'b1;
               w_start     = 1'b1;
               w_cnt_clr   = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (sample_tick) begin
               if (w_boundary) begin
                  w_cnt_clr = 1'b1;
                  if (r_sh_full) begin
                     w_swap = 1'b1;
                  end else begin
                     w_stop      = 1'b1;
                     w_state_nxt = S_IDLE;
                  end
               end else begin
                  w_cnt_inc = 1'b1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Shadow side: accept never coincides with swap, since accept needs !full and swap needs full
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_idx       <= '0;
         r_sh_full      <= 1'b0;
         r_sh_voiced    <= 1'b0;
         r_sh_pulserate <= '0;
         for (int k = 0; k < NCOEF; k++) r_sh_a[k] <= '0;
      end else begin
         if (w_swap) r_sh_full <= 1'b0;
         if (w_accept) begin
            if (r_wr_idx == IW'(0)) r_sh_voiced    <= in_data[0];
            if (r_wr_idx == IW'(1)) r_sh_pulserate <= in_data;
            for (int k = 0; k < NCOEF; k++)
               if (r_wr_idx == IW'(k + 2)) r_sh_a[k] <= in_data;
            if (w_last_word) begin
               r_wr_idx  <= '0;
               r_sh_full <= 1'b1;
            end else begin
               r_wr_idx  <= r_wr_idx + IW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_act_voiced    <= 1'b0;
         r_act_pulserate <= '0;
         for (int k = 0; k < NCOEF; k++) r_act_a[k] <= '0;
         r_count         <= '0;
         r_frame_count   <= '0;
         r_start         <= 1'b0;
         r_stop          <= 1'b0;
         r_underrun      <= 1'b0;
      end else begin
         r_start    <= w_start;
         r_stop     <= w_stop;
         r_underrun <= w_stop;
         if (w_cnt_clr)      r_count <= '0;
         else if (w_cnt_inc) r_count <= r_count + DW'(1);
         if (w_swap) begin
            r_act_voiced    <= r_sh_voiced;
            r_act_pulserate <= r_sh_pulserate;
            for (int k = 0; k < NCOEF; k++) r_act_a[k] <= r_sh_a[k];
            r_frame_count   <= r_frame_count + DW'(1);
         end
      end
   end

   assign in_ready    = !r_sh_full;
   assign start       = r_start;
   assign stop        = r_stop;
   assign underrun    = r_underrun;
   assign voiced      = r_act_voiced;
   assign pulserate   = r_act_pulserate;
   assign frame_count = r_frame_count;
   assign A0  = r_act_a[0];
   assign A1  = r_act_a[1];
   assign A2  = r_act_a[2];
   assign A3  = r_act_a[3];
   assign A4  = r_act_a[4];
   assign A5  = r_act_a[5];
   assign A6  = r_act_a[6];
   assign A7  = r_act_a[7];
   assign A8  = r_act_a[8];
   assign A9  = r_act_a[9];
   assign A10 = r_act_a[10];

endmodule

// File: tb/tb_lpc_frame_loader.sv
// tb/tb_lpc_frame_loader.sv - directed and randomized bench for lpc_frame_loader
module tb_lpc_frame_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic [15:0] lpcrate;
   logic        sample_tick;
   logic        start, stop, voiced, underrun;
   logic [15:0] pulserate, frame_count;
   logic signed [15:0] A0, A1, A2, A3, A4, A5, A6, A7, A8, A9, A10;

   int checks = 0;
   int errors = 0;

   lpc_frame_loader dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .lpcrate(lpcrate), .sample_tick(sample_tick), .start(start), .stop(stop),
      .voiced(voiced), .pulserate(pulserate),
      .A0(A0), .A1(A1), .A2(A2), .A3(A3), .A4(A4), .A5(A5), .A6(A6), .A7(A7), .A8(A8),
      .A9(A9), .A10(A10), .underrun(underrun), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   // Reference model: frame-level view of shadow and active frames
   bit          m_run, m_full;
   logic [15:0] m_part[$];
   logic [15:0] m_sh [13];
   logic [15:0] m_act [13];
   int          m_count;
   logic [15:0] m_fc;
   bit          e_start, e_stop;
   logic [15:0] frame [13];
   logic [15:0] a_out [11];
   logic [15:0] saved;

   always_comb begin
      a_out[0] = A0; a_out[1] = A1; a_out[2] = A2; a_out[3] = A3;
      a_out[4] = A4; a_out[5] = A5; a_out[6] = A6; a_out[7] = A7;
      a_out[8] = A8; a_out[9] = A9; a_out[10] = A10;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_full = 0; m_part.delete(); m_count = 0; m_fc = 0;
      e_start = 0; e_stop = 0;
      for (int i = 0; i < 13; i++) begin m_sh[i] = 0; m_act[i] = 0; end
   endtask

   task automatic check_all();
      chk("in_ready", {15'd0, in_ready}, {15'd0, !m_full});
      chk("start", {15'd0, start}, {15'd0, e_start});
      chk("stop", {15'd0, stop}, {15'd0, e_stop});
      chk("underrun", {15'd0, underrun}, {15'd0, e_stop});
      chk("voiced", {15'd0, voiced}, {15'd0, m_act[0][0]});
      chk("pulserate", pulserate, m_act[1]);
      for (int k = 0; k < 11; k++) chk($sformatf("A%0d", k), a_out[k], m_act[k + 2]);
      chk("frame_count", frame_count, m_fc);
   endtask

   task automatic do_swap();
      for (int i = 0; i < 13; i++) m_act[i] = m_sh[i];
      m_full = 0;
      m_fc++;
   endtask

   // One clock: predict from pre-edge model state, then compare after the edge
   task automatic step(input bit v, input logic [15:0] d, input bit t);
      bit acc;
      int rate;
      in_valid = v; in_data = d; sample_tick = t;
      acc = v && !m_full;
      e_start = 0; e_stop = 0;
      if (!m_run) begin
         if (m_full) begin do_swap(); m_run = 1; m_count = 0; e_start = 1; end
      end else if (t) begin
         rate = (lpcrate == 0) ? 1 : int'(lpcrate);
         if (m_count >= rate - 1) begin
            m_count = 0;
            if (m_full) do_swap();
            else begin e_stop = 1; m_run = 0; end
         end else m_count++;
      end
      if (acc) begin
         m_part.push_back(d);
         if (m_part.size() == 13) begin
            for (int i = 0; i < 13; i++) m_sh[i] = m_part[i];
            m_part.delete();
            m_full = 1;
         end
      end
      @(posedge clk); #1;
      check_all();
      in_valid = 0; sample_tick = 0;
   endtask

   task automatic rand_frame();
      for (int i = 0; i < 13; i++) frame[i] = 16'($urandom);
   endtask

   task automatic send_words(input int n);
      for (int i = 0; i < n; i++) step(1, frame[i], 0);
   endtask

   initial begin
      rst = 0; in_valid = 0; in_data = 0; lpcrate = 4; sample_tick = 0;
      model_reset();
      #12;
      chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
      chk("rst_frame_count", frame_count, 16'd0);
      chk("rst_A0", A0, 16'd0);
      check_all();
      @(posedge clk); #1; rst = 1;

      // First frame: start pulses one cycle after the last accept
      frame[0] = 16'h0001; frame[1] = 16'h0050; frame[2] = 16'h1000;
      for (int i = 3; i < 13; i++) frame[i] = 16'(i - 2);
      send_words(13);
      chk("full_in_ready", {15'd0, in_ready}, 16'd0);
      step(0, 0, 0);
      chk("t1_start", {15'd0, start}, 16'd1);
      chk("t1_voiced", {15'd0, voiced}, 16'd1);
      chk("t1_pulserate", pulserate, 16'h0050);
      chk("t1_A0", A0, 16'h1000);
      chk("t1_A10", A10, 16'd10);
      chk("t1_frame_count", frame_count, 16'd1);

      // Preloaded second frame swaps on the 4th tick
      lpcrate = 4;
      rand_frame();
      send_words(13);
      for (int i = 0; i < 4; i++) step(0, 0, 1);
      chk("t2_frame_count", frame_count, 16'd2);
      chk("t2_underrun", {15'd0, underrun}, 16'd0);
      chk("t2_A5", A5, frame[7]);
      chk("t2_in_ready", {15'd0, in_ready}, 16'd1);

      // No frame ready: underrun at the 4th tick, then idle ignores ticks
      for (int i = 0; i < 4; i++) step(0, 0, 1);
      chk("t3_underrun", {15'd0, underrun}, 16'd1);
      chk("t3_stop", {15'd0, stop}, 16'd1);
      chk("t3_A0_hold", A0, frame[2]);
      step(0, 0, 1);
      chk("t3_idle_tick", {14'd0, start, stop}, 16'd0);

      // lpcrate 0: every tick is a boundary
      lpcrate = 0;
      rand_frame();
      send_words(13);
      step(0, 0, 0);
      chk("t4_restart", {15'd0, start}, 16'd1);
      for (int r = 0; r < 3; r++) begin
         rand_frame();
         send_words(13);
         saved = frame_count;
         step(0, 0, 1);
         chk("t4_fc_inc", frame_count, saved + 16'd1);
         chk("t4_pulserate", pulserate, frame[1]);
      end

      // Last word on the same edge as a boundary tick
      rand_frame();
      send_words(12);
      step(1, frame[12], 1);
      chk("t5_underrun", {15'd0, underrun}, 16'd1);
      step(0, 0, 0);
      chk("t5_start", {15'd0, start}, 16'd1);
      chk("t5_A10", A10, frame[12]);

      // Reset mid-stream at wr_idx 5
      rand_frame();
      send_words(5);
      rst = 0; #1;
      model_reset();
      chk("t6_frame_count", frame_count, 16'd0);
      chk("t6_pulserate", pulserate, 16'd0);
      check_all();
      @(posedge clk); #1; rst = 1;
      rand_frame();
      send_words(13);
      step(0, 0, 0);
      chk("t6_start", {15'd0, start}, 16'd1);
      chk("t6_A0", A0, frame[2]);
      chk("t6_fc", frame_count, 16'd1);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 49) == 0) lpcrate = 16'($urandom_range(0, 6));
         step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lpc_frame_loader.md
Name: lpc_frame_loader

Overview:
- Upstream parameter feeder for the LPC decoder.
- Accepts a stream of 16-bit frame words (flags, pulse rate, A0..A10) into a shadow buffer.
- Swaps the shadow buffer into held active registers at each frame boundary, counted in synthesis sample ticks.
- Generates the decoder's start/stop strobes and flags underrun when no new frame is ready at a boundary.

Parameters:
- NCOEF, 11, number of predictor coefficients (A0..A10); frame length is NCOEF+2 words.
- DW, 16, data width of stream words, coefficients and counters.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  stream word valid.
- in_data  in  16  stream word. Word0 bit0 = voiced (other bits ignored); word1 = pulserate; words 2..12 = A0..A10 (signed).
- in_ready  out  1  loader can accept a word.
- lpcrate  in  16  samples per frame; 0 is treated as 1.
- sample_tick  in  1  one-cycle strobe per synthesized sample (decoder output valid).
- start  out  1  one-cycle pulse when the first frame after idle becomes active.
- stop  out  1  one-cycle pulse when the loader returns to idle on underrun.
- voiced  out  1  active frame voiced flag.
- pulserate  out  16  active frame pulse rate.
- A0..A10  out  16 each, signed  active frame coefficients.
- underrun  out  1  one-cycle pulse at a boundary with no shadow frame ready.
- frame_count  out  16  number of frames made active; wraps.

Behaviour:
- Reset (rst low, asynchronous):
  - state IDLE; shadow empty; wr_idx=0; sample count=0.
  - All outputs 0: in_ready=1, start, stop, underrun, voiced, pulserate, A0..A10, frame_count.
- Write side:
  - in_ready = !shadow_full. A word is accepted on a clock edge with in_valid && in_ready.
  - wr_idx 0 -> sh_voiced=in_data[0]; 1 -> sh_pulserate; k in 2..12 -> sh_A[k-2].
  - Accept at wr_idx=12 sets shadow_full and returns wr_idx to 0.
  - shadow_full is a registered flag, visible the cycle after the last word is accepted.
- Swap: active registers <= shadow; shadow_full <= 0; frame_count <= frame_count+1. in_ready rises the cycle after a swap.
- State IDLE:
  - sample_tick is ignored; active outputs hold their last values.
  - When shadow_full=1: swap, count<=0, start=1 for one cycle (same edge as the new coefficients appear), go to RUN.
- State RUN, on sample_tick:
  - Boundary when count == max(lpcrate,1)-1. count <= 0.
  - Boundary with shadow_full=1: swap, stay in RUN.
  - Boundary with shadow_full=0: underrun=1 and stop=1 for one cycle; active registers hold; go to IDLE.
  - Not a boundary: count <= count+1.
  - No sample_tick: count holds.
- lpcrate is sampled on every tick. If a change makes count > lpcrate-1, the next tick is a boundary (compare with >=).
- Simultaneous events:
  - Last word accepted on the same edge as a boundary tick: the shadow is not yet full, so this is an underrun -> IDLE. The next cycle restarts via IDLE (start pulses again).
  - Stream words arriving mid-frame fill the shadow freely; a partial shadow never swaps.
- frame_count wraps 16'hFFFF -> 0.
- Reset mid-frame discards any partial shadow and the active frame.
- Latency: coefficients change exactly on the edge following the boundary tick's edge sampling, i.e. registered on the boundary tick edge. No combinational path from sample_tick to outputs.

Test Plan:
- Reset, then stream 13 words (0x0001, 0x0050, A0=0x1000, A1..A10=1..10) -> one cycle after the last accept: start=1, voiced=1, pulserate=0x0050, A0=0x1000, A10=10, frame_count=1.
- lpcrate=4, second frame preloaded, 4 ticks -> swap on the 4th tick; no underrun; frame_count=2; in_ready high the next cycle.
- lpcrate=4, no second frame, 4 ticks -> underrun=1 and stop=1 for one cycle, state IDLE, coefficients unchanged; a 5th tick produces no activity.
- lpcrate=0 with shadow refilled each time -> every tick is a boundary; frame_count increments per tick.
- Last shadow word accepted on the same edge as a boundary tick -> underrun/stop; the next cycle start=1 with the new frame.
- Assert rst low mid-stream (wr_idx=5) -> all outputs 0 immediately; re-sent full frame loads correctly from word0.
